// File: rtl/raster_pos_tracker.sv
// Raster position tracker: accepts a raster-ordered pixel stream over valid/ready,
// tracks column/row and re-emits each pixel one cycle later through a single
// output register, tagged with its position, frame markers and a 3x3-window flag.
// Ports:
//   clk_i, rstn_i           clock, async active-low reset
//   clear_i                 synchronous frame abort/restart
//   valid_i/ready_o/data_i  input stream
//   valid_o/ready_i/data_o  output stream (registered)
//   col_o, row_o            position of the output pixel
//   sof_o/eol_o/eof_o       start-of-frame, end-of-line, end-of-frame tags
//   win_valid_o             full 3x3 window available (row>=2 and col>=2)
//   busy_o                  a frame is in progress
//   frame_cnt_o             completed frames (wrapping)
//   frame_done_o            one-cycle pulse after the eof beat leaves
module raster_pos_tracker #(
  parameter int unsigned DATA_W_P  = 8,
  parameter int unsigned IMG_W_P   = 640,
  parameter int unsigned IMG_H_P   = 480,
  parameter int unsigned FRAME_W_P = 16,
  localparam int unsigned COL_W_P  = $clog2(IMG_W_P),
  localparam int unsigned ROW_W_P  = $clog2(IMG_H_P)
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 clear_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [DATA_W_P-1:0]  data_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [DATA_W_P-1:0]  data_o,
  output logic [COL_W_P-1:0]   col_o,
  output logic [ROW_W_P-1:0]   row_o,
  output logic                 sof_o,
  output logic                 eol_o,
  output logic                 eof_o,
  output logic                 win_valid_o,
  output logic                 busy_o,
  output logic [FRAME_W_P-1:0] frame_cnt_o,
  output logic                 frame_done_o
);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  localparam logic [COL_W_P-1:0] ColLast = COL_W_P'(IMG_W_P - 1);
  localparam logic [ROW_W_P-1:0] RowLast = ROW_W_P'(IMG_H_P - 1);

  state_e                state_q, state_d;
  logic [COL_W_P-1:0]    col_q, col_d;
  logic [ROW_W_P-1:0]    row_q, row_d;
  logic                  valid_q, valid_d;
  logic [DATA_W_P-1:0]   data_q, data_d;
  logic [COL_W_P-1:0]    ocol_q, ocol_d;
  logic [ROW_W_P-1:0]    orow_q, orow_d;
  logic                  sof_q, sof_d, eol_q, eol_d, eof_q, eof_d, win_q, win_d;
  logic [FRAME_W_P-1:0]  fcnt_q, fcnt_d;
  logic                  fdone_q, fdone_d;

  logic in_fire, out_fire;
  logic cur_sof, cur_eol, cur_eof, cur_win;

  assign ready_o  = ~valid_q | ready_i;
  // clear_i blocks capture even though ready_o still follows its equation.
  assign in_fire  = valid_i & ready_o & ~clear_i;
  assign out_fire = valid_q & ready_i;

  assign cur_sof = (col_q == '0) && (row_q == '0);
  assign cur_eol = (col_q == ColLast);
  assign cur_eof = cur_eol && (row_q == RowLast);
  assign cur_win = (col_q >= COL_W_P'(2)) && (row_q >= ROW_W_P'(2));

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    valid_d = valid_q;
    data_d  = data_q;
    ocol_d  = ocol_q;
    orow_d  = orow_q;
    sof_d   = sof_q;
    eol_d   = eol_q;
    eof_d   = eof_q;
    win_d   = win_q;
    fcnt_d  = fcnt_q;
    fdone_d = 1'b0;

    if (clear_i) begin
      // Abort: drop the pending beat and restart at (0,0); frame count is kept.
      state_d = StIdle;
      col_d   = '0;
      row_d   = '0;
      valid_d = 1'b0;
    end else begin
      if (in_fire) begin
        valid_d = 1'b1;
        data_d  = data_i;
        ocol_d  = col_q;
        orow_d  = row_q;
        sof_d   = cur_sof;
        eol_d   = cur_eol;
        eof_d   = cur_eof;
        win_d   = cur_win;
        if (cur_eol) begin
          col_d = '0;
          row_d = (row_q == RowLast) ? '0 : row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
        state_d = cur_eof ? StIdle : StActive;
      end else if (out_fire) begin
        valid_d = 1'b0;
      end
      if (out_fire && eof_q) begin
        fdone_d = 1'b1;
        fcnt_d  = fcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= StIdle;
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      ocol_q  <= '0;
      orow_q  <= '0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      win_q   <= 1'b0;
      fcnt_q  <= '0;
      fdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ocol_q  <= ocol_d;
      orow_q  <= orow_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
      win_q   <= win_d;
      fcnt_q  <= fcnt_d;
      fdone_q <= fdone_d;
    end
  end

  assign valid_o      = valid_q;
  assign data_o       = data_q;
  assign col_o        = ocol_q;
  assign row_o        = orow_q;
  assign sof_o        = sof_q;
  assign eol_o        = eol_q;
  assign eof_o        = eof_q;
  assign win_valid_o  = win_q;
  assign busy_o       = (state_q == StActive);
  assign frame_cnt_o  = fcnt_q;
  assign frame_done_o = fdone_q;

endmodule

// File: tb/tb_raster_pos_tracker.sv
// Directed bench for raster_pos_tracker with a 4x3 image.
module tb_raster_pos_tracker;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       clear = 1'b0;
  logic       valid_in = 1'b0;
  logic       ready_out;
  logic [7:0] data_in = '0;
  logic       valid_out;
  logic       ready_in = 1'b1;
  logic [7:0] data_out;
  logic [1:0] col, row;
  logic       sof, eol, eof, win, busy;
  logic [15:0] frame_cnt;
  logic       frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  raster_pos_tracker #(
    .DATA_W_P (8),
    .IMG_W_P  (4),
    .IMG_H_P  (3),
    .FRAME_W_P(16)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .clear_i     (clear),
    .valid_i     (valid_in),
    .ready_o     (ready_out),
    .data_i      (data_in),
    .valid_o     (valid_out),
    .ready_i     (ready_in),
    .data_o      (data_out),
    .col_o       (col),
    .row_o       (row),
    .sof_o       (sof),
    .eol_o       (eol),
    .eof_o       (eof),
    .win_valid_o (win),
    .busy_o      (busy),
    .frame_cnt_o (frame_cnt),
    .frame_done_o(frame_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected {valid, data, col, row, sof, eol, eof, win} for the idx-th pixel of a 4x3 frame.
  function automatic logic [16:0] exp_px(input int idx, input logic [7:0] d);
    int c;
    int r;
    c = idx % 4;
    r = idx / 4;
    return {1'b1, d, 2'(c), 2'(r), (c == 0 && r == 0), (c == 3), (c == 3 && r == 2),
            (c >= 2 && r >= 2)};
  endfunction

  function automatic logic [16:0] obs_px();
    return {valid_out, data_out, col, row, sof, eol, eof, win};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    int in_idx;
    int out_idx;
    logic pending;
    logic exp_ready;
    logic [3:0] pat;
    pat = 4'b1001;  // ready_i sequence 1,0,0,1 read from bit 3 down

    // Reset state
    apply_reset();
    check_eq("rst_px", 32'(obs_px()), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_fcnt", 32'(frame_cnt), 32'h0);
    check_eq("rst_done", 32'(frame_done), 32'h0);
    check_eq("rst_ready", 32'(ready_out), 32'h1);

    // Frame 1: full throughput
    valid_in = 1'b1;
    data_in  = 8'h10;
    for (int i = 0; i < 12; i++) begin
      step();
      check_eq($sformatf("f1_px%0d", i), 32'(obs_px()), 32'(exp_px(i, 8'(8'h10 + i))));
      if (i == 0)  check_eq("f1_busy_start", 32'(busy), 32'h1);
      if (i == 11) check_eq("f1_busy_end", 32'(busy), 32'h0);
      if (i == 11) check_eq("f1_done_early", 32'(frame_done), 32'h0);
      if (i < 11) data_in = 8'(8'h11 + i);
      else valid_in = 1'b0;
    end
    step();
    check_eq("f1_valid_drain", 32'(valid_out), 32'h0);
    check_eq("f1_done", 32'(frame_done), 32'h1);
    check_eq("f1_fcnt", 32'(frame_cnt), 32'h1);
    step();
    check_eq("f1_done_pulse", 32'(frame_done), 32'h0);

    // Frame 2: downstream stalls with ready_i 1,0,0,1
    in_idx  = 0;
    out_idx = 0;
    for (int c = 0; c < 100 && out_idx < 12; c++) begin
      ready_in = pat[3 - (c % 4)];
      valid_in = (in_idx < 12);
      data_in  = 8'(8'h10 + in_idx);
      #1;
      pending   = (in_idx > out_idx);
      exp_ready = !pending || ready_in;
      check_eq($sformatf("f2_valid_c%0d", c), 32'(valid_out), 32'(pending));
      check_eq($sformatf("f2_ready_c%0d", c), 32'(ready_out), 32'(exp_ready));
      if (pending)
        check_eq($sformatf("f2_px_c%0d", c), 32'(obs_px()),
                 32'(exp_px(out_idx, 8'(8'h10 + out_idx))));
      if (pending && ready_in) out_idx++;
      if (valid_in && exp_ready) in_idx++;
      @(posedge clk);
      #1;
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    check_eq("f2_done", 32'(frame_done), 32'h1);
    check_eq("f2_fcnt", 32'(frame_cnt), 32'h2);

    // Two frames back-to-back after a fresh reset
    apply_reset();
    valid_in = 1'b1;
    data_in  = 8'h40;
    for (int i = 0; i < 24; i++) begin
      step();
      check_eq($sformatf("b2b_px%0d", i), 32'(obs_px()), 32'(exp_px(i % 12, 8'(8'h40 + i))));
      if (i == 12) begin
        check_eq("b2b_done_mid", 32'(frame_done), 32'h1);
        check_eq("b2b_fcnt_mid", 32'(frame_cnt), 32'h1);
      end
      if (i < 23) data_in = 8'(8'h41 + i);
      else valid_in = 1'b0;
    end
    step();
    check_eq("b2b_done", 32'(frame_done), 32'h1);
    check_eq("b2b_fcnt", 32'(frame_cnt), 32'h2);

    // clear_i after the 6th accepted pixel
    valid_in = 1'b1;
    data_in  = 8'h30;
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq($sformatf("clr_px%0d", i), 32'(obs_px()), 32'(exp_px(i, 8'(8'h30 + i))));
      data_in = 8'(8'h31 + i);
    end
    check_eq("clr_busy_pre", 32'(busy), 32'h1);
    clear    = 1'b1;
    data_in  = 8'h55;  // offered during clear, must not be captured
    step();
    check_eq("clr_valid", 32'(valid_out), 32'h0);
    check_eq("clr_busy", 32'(busy), 32'h0);
    check_eq("clr_fcnt", 32'(frame_cnt), 32'h2);
    check_eq("clr_done", 32'(frame_done), 32'h0);
    clear   = 1'b0;
    data_in = 8'hA0;
    step();
    check_eq("clr_restart", 32'(obs_px()), 32'(exp_px(0, 8'hA0)));
    data_in = 8'hA1;
    step();
    check_eq("clr_next", 32'(obs_px()), 32'(exp_px(1, 8'hA1)));

    // Async reset mid-frame while valid_o is high
    data_in = 8'hA2;
    step();
    check_eq("ar_pre", 32'(obs_px()), 32'(exp_px(2, 8'hA2)));
    #2;
    rstn = 1'b0;
    #1;
    check_eq("ar_px", 32'(obs_px()), 32'h0);
    check_eq("ar_busy", 32'(busy), 32'h0);
    check_eq("ar_fcnt", 32'(frame_cnt), 32'h0);
    check_eq("ar_done", 32'(frame_done), 32'h0);
    @(posedge clk);
    #1;
    rstn    = 1'b1;
    data_in = 8'hC0;
    step();
    check_eq("ar_restart", 32'(obs_px()), 32'(exp_px(0, 8'hC0)));
    valid_in = 1'b0;
    step();
    check_eq("ar_drain", 32'(valid_out), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/raster_pos_tracker.md
Name: raster_pos_tracker

Overview:
- Stream-position stage directly upstream of the Sobel window/line-buffer logic.
- Accepts a raster-ordered pixel stream over valid/ready and tracks column and row with two internal up-counters (column wraps, row advances on column wrap).
- Re-emits each pixel through a single registered output slice, tagged with its position, frame markers and a 3x3-window-valid flag.
- Keeps a frame counter and a frame-done pulse for downstream control.

Parameters:
- DATA_W_P, 8, pixel width in bits.
- IMG_W_P, 640, pixels per line; must be ≥3.
- IMG_H_P, 480, lines per frame; must be ≥3.
- FRAME_W_P, 16, frame counter width.
- COL_W_P, $clog2(IMG_W_P), column width (derived, not overridden).
- ROW_W_P, $clog2(IMG_H_P), row width (derived, not overridden).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rstn_i  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous frame abort/restart.
- valid_i  in  1  input pixel valid.
- ready_o  out  1  input ready.
- data_i  in  DATA_W_P  input pixel.
- valid_o  out  1  output beat valid.
- ready_i  in  1  downstream ready.
- data_o  out  DATA_W_P  registered pixel.
- col_o  out  COL_W_P  column of the output pixel.
- row_o  out  ROW_W_P  row of the output pixel.
- sof_o  out  1  output pixel is (0,0).
- eol_o  out  1  output pixel is the last column.
- eof_o  out  1  output pixel is the last pixel of the frame.
- win_valid_o  out  1  row_o≥2 and col_o≥2 (full 3x3 window centred at row-1, col-1).
- busy_o  out  1  state is ACTIVE.
- frame_cnt_o  out  FRAME_W_P  completed frames, modulo 2^FRAME_W_P.
- frame_done_o  out  1  one-cycle pulse when an eof beat handshakes on the output.

Behaviour:
- Reset, asynchronous on rstn_i low: valid_o=0; data_o, col_o, row_o, all flags, frame_cnt_o and internal col/row counters = 0; frame_done_o=0; state=IDLE. Release is synchronous to clk_i.
- Input handshake: in_fire = valid_i & ready_o. Output handshake: out_fire = valid_o & ready_i.
- ready_o = ~valid_o | ready_i. This is combinational and gives full throughput; no skid buffer.
- Output register: on in_fire, the register loads data_i plus the tags computed from the current internal col/row, and valid_o=1 next cycle. Otherwise, if out_fire, valid_o=0. Latency is 1 cycle. Outputs hold stable while valid_o & ~ready_i.
- Internal counters advance only on in_fire.
  - col: if col==IMG_W_P-1, col←0; else col+1.
  - row: on column wrap, row←0 if row==IMG_H_P-1, else row+1.
  - Counters never exceed their limits; there is no saturation mode.
- Tags:
  - sof = (col==0 & row==0).
  - eol = (col==IMG_W_P-1).
  - eof = eol & (row==IMG_H_P-1).
  - win_valid = (col≥2 & row≥2).
- FSM, two states:
  - IDLE → ACTIVE on in_fire.
  - ACTIVE → IDLE on in_fire of the eof pixel (counters back at 0,0).
  - clear_i forces IDLE from either state.
- frame_cnt_o increments by 1 (wrapping) in the same cycle frame_done_o is asserted.
- frame_done_o = registered (out_fire & eof_o); asserted the cycle after the eof beat leaves.
- clear_i, in the same cycle, takes priority over everything:
  - counters→0, valid_o→0 (the pending beat is dropped), state→IDLE, frame_done_o→0.
  - frame_cnt_o is held.
  - ready_o still follows its equation, but no input is captured that cycle.
- Back-to-back frames: the pixel accepted after eof is tagged sof with no bubble.
- Mid-frame reset: everything returns to reset values immediately; the next accepted pixel is (0,0).

Test Plan (IMG_W_P=4, IMG_H_P=3):
- Reset, then 12 pixels 0x10..0x1B with valid_i=1 and ready_i=1 → outputs appear 1 cycle later with col 0,1,2,3,0,…; row 0,0,0,0,1,…,2; sof only on 0x10; eol on 0x13, 0x17, 0x1B; eof on 0x1B. frame_done_o pulses 1 cycle after 0x1B leaves; frame_cnt_o=1.
- Same frame with ready_i toggling 1,0,0,1 → no beat lost or duplicated; data_o/col_o/row_o stable while stalled; ready_o=0 only when valid_o=1 and ready_i=0.
- win_valid_o check across the frame → asserted only for (row2,col2)=0x1A and (row2,col3)=0x1B.
- Two frames back-to-back → the 13th pixel carries sof=1 with col=0, row=0, no idle cycle; frame_cnt_o=2 after the second eof.
- clear_i asserted after the 6th accepted pixel → valid_o=0 next cycle, busy_o=0, frame_cnt_o unchanged; the next accepted pixel is tagged (0,0) with sof=1.
- rstn_i pulsed low mid-frame while valid_o=1 → all outputs 0 immediately, without waiting for a clock edge; restart from (0,0).
